// File: rtl/seq_controller_if.sv
// Shared-bus bundle between the tiny16 sequencer and its datapath (ALU, memory, register file).
// Latency: none, pure wiring.
// Backpressure: mem_ready stalls memory steps; the controller never sees any other stall.
interface seq_controller_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic [DATA_W-1:0] in;
  logic [3:0]        flags;
  logic              mem_ready;
  logic [3:0]        alu_opcode;
  logic              alu_out_en;
  logic              alu_ar_flag;
  logic              mem_addr_en;
  logic              mem_in_en;
  logic              mem_out_en;
  logic [REG_W-1:0]  reg_src_sel;
  logic [REG_W-1:0]  reg_dst_sel;
  logic              reg_in_en;
  logic              reg_out_en;
  logic              reg_pc_inc;
  logic              ctl_out_en;
  logic [DATA_W-1:0] out;
  logic [2:0]        step;
  logic              halted;

  // Controller side
  modport master (
    input  in, flags, mem_ready,
    output alu_opcode, alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en,
           reg_src_sel, reg_dst_sel, reg_in_en, reg_out_en, reg_pc_inc, ctl_out_en,
           out, step, halted
  );

  // Datapath side
  modport slave (
    output in, flags, mem_ready,
    input  alu_opcode, alu_out_en, alu_ar_flag, mem_addr_en, mem_in_en, mem_out_en,
           reg_src_sel, reg_dst_sel, reg_in_en, reg_out_en, reg_pc_inc, ctl_out_en,
           out, step, halted
  );
endinterface

// File: rtl/seq_controller.sv
// tiny16 instruction sequencer: fetch/execute FSM driving ALU, memory and register strobes.
// Latency: strobes for a step are valid in the cycle the FSM sits in that step (registered from next state).
// Backpressure: F1 and LD/ST E2 hold while mem_ready=0 (unless WAIT_EN=0); HALT holds until rst.
module seq_controller #(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 3,
  parameter int PC_SEL  = 7,
  parameter int WAIT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  seq_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_F0   = 3'd1,
    S_F1   = 3'd2,
    S_E1   = 3'd3,
    S_E2   = 3'd4,
    S_E3   = 3'd5,
    S_HALT = 3'd7
  } state_e;

  // Registered strobe image of a step. The last three fields qualify strobes that
  // depend on same-cycle inputs (mem_ready, flags) and cannot be fully precomputed.
  typedef struct packed {
    logic [3:0]        alu_opcode;
    logic              alu_out_en;
    logic              alu_ar_flag;
    logic              mem_addr_en;
    logic              mem_in_en;
    logic              mem_out_en;
    logic [REG_W-1:0]  reg_src_sel;
    logic [REG_W-1:0]  reg_dst_sel;
    logic              reg_in_en;
    logic              reg_out_en;
    logic              ctl_out_en;
    logic [DATA_W-1:0] out;
    logic [2:0]        step;
    logic              halted;
    logic              pc_arm;    // F1: PC increments in the cycle the fetch completes
    logic              wr_wait;   // LD E2: register write only in the ready cycle
    logic              jmp_en;    // JMP E1: write enable comes from live flags vs mask
    logic [3:0]        jmp_mask;
  } ctl_t;

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_SEL);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctl_t        ctl_q, ctl_d;
  logic        ready;
  logic        reg_in_fin;
  logic        jmp_take;
  logic [3:0]  op_q;
  logic [3:0]  op_d;

  assign ready = bus.mem_ready | (WAIT_EN == 0);
  assign op_q  = ir_q[15:12];
  assign op_d  = ir_d[15:12];

  // Bits above the 16-bit instruction field carry no decode meaning.
  if (DATA_W > 16) begin : g_hi
    logic unused_in_hi;
    assign unused_in_hi = ^bus.in[DATA_W-1:16];
  end

  // Next state and instruction register
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_RST: state_d = S_F0;
      S_F0:  state_d = S_F1;
      S_F1: begin
        if (ready) begin
          ir_d    = bus.in[15:0];
          state_d = (bus.in[15:12] == 4'h7) ? S_HALT : S_E1;
        end
      end
      S_E1: begin
        if (op_q == 4'h2 || op_q == 4'h3 || op_q[3]) state_d = S_E2;
        else                                          state_d = S_F0;
      end
      S_E2: begin
        if (op_q[3])    state_d = S_E3;
        else if (ready) state_d = S_F0;
      end
      S_E3:    state_d = S_F0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Strobe decode of the step being entered, so outputs come straight from flops
  always_comb begin
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src;
    dst        = REG_W'(ir_d[11:9]);
    src        = REG_W'(ir_d[8:6]);
    ctl_d      = '0;
    ctl_d.step = state_d;
    case (state_d)
      S_F0: begin
        ctl_d.reg_src_sel = PC_IDX;
        ctl_d.reg_out_en  = 1'b1;
        ctl_d.mem_addr_en = 1'b1;
      end
      S_F1: begin
        ctl_d.mem_out_en = 1'b1;
        ctl_d.pc_arm     = 1'b1;
      end
      S_E1: begin
        case (op_d)
          4'h1: begin
            ctl_d.reg_src_sel = src;
            ctl_d.reg_out_en  = 1'b1;
            ctl_d.reg_dst_sel = dst;
            ctl_d.reg_in_en   = 1'b1;
          end
          4'h2: begin
            ctl_d.reg_src_sel = src;
            ctl_d.reg_out_en  = 1'b1;
            ctl_d.mem_addr_en = 1'b1;
          end
          4'h3: begin
            ctl_d.reg_src_sel = dst;
            ctl_d.reg_out_en  = 1'b1;
            ctl_d.mem_addr_en = 1'b1;
          end
          4'h4: begin
            ctl_d.ctl_out_en  = 1'b1;
            ctl_d.out         = DATA_W'(ir_d[5:0]);
            ctl_d.reg_dst_sel = dst;
            ctl_d.reg_in_en   = 1'b1;
          end
          4'h5: begin
            ctl_d.reg_src_sel = src;
            ctl_d.reg_out_en  = 1'b1;
            ctl_d.reg_dst_sel = PC_IDX;
            ctl_d.jmp_en      = 1'b1;
            ctl_d.jmp_mask    = ir_d[3:0];
          end
          default: begin
            if (op_d[3]) begin
              ctl_d.reg_src_sel = dst;
              ctl_d.reg_out_en  = 1'b1;
              ctl_d.alu_ar_flag = 1'b1;
            end
          end
        endcase
      end
      S_E2: begin
        if (op_d == 4'h2) begin
          ctl_d.mem_out_en  = 1'b1;
          ctl_d.reg_dst_sel = dst;
          ctl_d.reg_in_en   = 1'b1;
          ctl_d.wr_wait     = 1'b1;
        end else if (op_d == 4'h3) begin
          ctl_d.reg_src_sel = src;
          ctl_d.reg_out_en  = 1'b1;
          ctl_d.mem_in_en   = 1'b1;
        end else if (op_d[3]) begin
          ctl_d.reg_src_sel = src;
          ctl_d.reg_out_en  = 1'b1;
          ctl_d.alu_opcode  = op_d;
        end
      end
      S_E3: begin
        ctl_d.alu_opcode  = op_d;
        ctl_d.alu_out_en  = 1'b1;
        ctl_d.reg_dst_sel = dst;
        ctl_d.reg_in_en   = 1'b1;
      end
      S_HALT:  ctl_d.halted = 1'b1;
      default: ctl_d = '0;
    endcase
  end

  // Single FSM register: state, IR and the registered strobe image
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      ir_q    <= '0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ctl_q   <= ctl_d;
    end
  end

  // Input-qualified register write: JMP condition, LD waits for the data beat
  always_comb begin
    jmp_take   = (ctl_q.jmp_mask == 4'h0) | (|(bus.flags & ctl_q.jmp_mask));
    reg_in_fin = ctl_q.jmp_en ? jmp_take : (ctl_q.reg_in_en & (~ctl_q.wr_wait | ready));
  end

  assign bus.alu_opcode  = ctl_q.alu_opcode;
  assign bus.alu_out_en  = ctl_q.alu_out_en;
  assign bus.alu_ar_flag = ctl_q.alu_ar_flag;
  assign bus.mem_addr_en = ctl_q.mem_addr_en;
  assign bus.mem_in_en   = ctl_q.mem_in_en;
  assign bus.mem_out_en  = ctl_q.mem_out_en;
  assign bus.reg_src_sel = ctl_q.reg_src_sel;
  assign bus.reg_dst_sel = reg_in_fin ? ctl_q.reg_dst_sel : '0;
  assign bus.reg_in_en   = reg_in_fin;
  assign bus.reg_out_en  = ctl_q.reg_out_en;
  assign bus.reg_pc_inc  = ctl_q.pc_arm & ready;
  assign bus.ctl_out_en  = ctl_q.ctl_out_en;
  assign bus.out         = ctl_q.out;
  assign bus.step        = ctl_q.step;
  assign bus.halted      = ctl_q.halted;

endmodule

// File: tb/tb_seq_controller.sv
// Bench for seq_controller: directed literal checks plus random instruction stream vs microcode model.
// Latency: model expects step strobes in the cycle after the edge that enters the step.
// Backpressure: mem_ready randomised; model holds stalling micro-steps until ready.
module tb_seq_controller;
  localparam int DW = 20;

  localparam int K_RST  = 0;
  localparam int K_F0   = 1;
  localparam int K_F1   = 2;
  localparam int K_EX   = 3;
  localparam int K_HALT = 4;

  typedef struct packed {
    logic [3:0]    alu_opcode;
    logic          alu_out_en;
    logic          alu_ar_flag;
    logic          mem_addr_en;
    logic          mem_in_en;
    logic          mem_out_en;
    logic [2:0]    reg_src_sel;
    logic [2:0]    reg_dst_sel;
    logic          reg_in_en;
    logic          reg_out_en;
    logic          reg_pc_inc;
    logic          ctl_out_en;
    logic [DW-1:0] out;
    logic [2:0]    step;
    logic          halted;
  } out_t;

  typedef struct {
    int         kind;
    out_t       exp;
    logic       wait_rdy;
    logic       gate_rdy;
    logic       jmp;
    logic [3:0] mask;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  ent_t q[$];

  seq_controller_if #(.DATA_W(DW), .REG_W(3)) bus_if ();

  seq_controller #(.DATA_W(DW), .REG_W(3), .PC_SEL(7), .WAIT_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic out_t dut_outs();
    out_t o;
    o.alu_opcode  = bus_if.alu_opcode;
    o.alu_out_en  = bus_if.alu_out_en;
    o.alu_ar_flag = bus_if.alu_ar_flag;
    o.mem_addr_en = bus_if.mem_addr_en;
    o.mem_in_en   = bus_if.mem_in_en;
    o.mem_out_en  = bus_if.mem_out_en;
    o.reg_src_sel = bus_if.reg_src_sel;
    o.reg_dst_sel = bus_if.reg_dst_sel;
    o.reg_in_en   = bus_if.reg_in_en;
    o.reg_out_en  = bus_if.reg_out_en;
    o.reg_pc_inc  = bus_if.reg_pc_inc;
    o.ctl_out_en  = bus_if.ctl_out_en;
    o.out         = bus_if.out;
    o.step        = bus_if.step;
    o.halted      = bus_if.halted;
    return o;
  endfunction

  function automatic ent_t new_ent(input int kind, input logic [2:0] stepc);
    ent_t e;
    e.kind     = kind;
    e.exp      = '0;
    e.exp.step = stepc;
    e.wait_rdy = 1'b0;
    e.gate_rdy = 1'b0;
    e.jmp      = 1'b0;
    e.mask     = 4'h0;
    return e;
  endfunction

  // Instruction -> list of execute micro-steps with their expected strobes
  task automatic push_instr(input logic [15:0] w);
    logic [3:0] op;
    logic [2:0] d;
    logic [2:0] s;
    ent_t e1, e2, e3;
    op = w[15:12];
    d  = w[11:9];
    s  = w[8:6];
    e1 = new_ent(K_EX, 3'd3);
    e2 = new_ent(K_EX, 3'd4);
    e3 = new_ent(K_EX, 3'd5);
    if (op == 4'h7) begin
      e1 = new_ent(K_HALT, 3'd7);
      e1.exp.halted = 1'b1;
      q.push_back(e1);
    end else if (op == 4'h1) begin
      e1.exp.reg_src_sel = s; e1.exp.reg_out_en = 1; e1.exp.reg_dst_sel = d; e1.exp.reg_in_en = 1;
      q.push_back(e1);
    end else if (op == 4'h2) begin
      e1.exp.reg_src_sel = s; e1.exp.reg_out_en = 1; e1.exp.mem_addr_en = 1;
      e2.exp.mem_out_en = 1; e2.exp.reg_dst_sel = d; e2.exp.reg_in_en = 1;
      e2.wait_rdy = 1; e2.gate_rdy = 1;
      q.push_back(e1); q.push_back(e2);
    end else if (op == 4'h3) begin
      e1.exp.reg_src_sel = d; e1.exp.reg_out_en = 1; e1.exp.mem_addr_en = 1;
      e2.exp.reg_src_sel = s; e2.exp.reg_out_en = 1; e2.exp.mem_in_en = 1;
      e2.wait_rdy = 1;
      q.push_back(e1); q.push_back(e2);
    end else if (op == 4'h4) begin
      e1.exp.ctl_out_en = 1; e1.exp.out = DW'(w[5:0]); e1.exp.reg_dst_sel = d; e1.exp.reg_in_en = 1;
      q.push_back(e1);
    end else if (op == 4'h5) begin
      e1.exp.reg_src_sel = s; e1.exp.reg_out_en = 1; e1.exp.reg_dst_sel = 3'd7;
      e1.jmp = 1; e1.mask = w[3:0];
      q.push_back(e1);
    end else if (op >= 4'h8) begin
      e1.exp.reg_src_sel = d; e1.exp.reg_out_en = 1; e1.exp.alu_ar_flag = 1;
      e2.exp.reg_src_sel = s; e2.exp.reg_out_en = 1; e2.exp.alu_opcode = op;
      e3.exp.alu_opcode = op; e3.exp.alu_out_en = 1; e3.exp.reg_dst_sel = d; e3.exp.reg_in_en = 1;
      q.push_back(e1); q.push_back(e2); q.push_back(e3);
    end else begin
      q.push_back(e1);
    end
  endtask

  function automatic ent_t f0_ent();
    ent_t e;
    e = new_ent(K_F0, 3'd1);
    e.exp.reg_src_sel = 3'd7; e.exp.reg_out_en = 1; e.exp.mem_addr_en = 1;
    return e;
  endfunction

  function automatic ent_t f1_ent();
    ent_t e;
    e = new_ent(K_F1, 3'd2);
    e.exp.mem_out_en = 1;
    return e;
  endfunction

  // Move the model across one clock edge using the inputs held during the cycle
  task automatic model_advance();
    ent_t h;
    logic rdy;
    rdy = bus_if.mem_ready;
    if (rst) begin
      q.delete();
      q.push_back(new_ent(K_RST, 3'd0));
      return;
    end
    h = q[0];
    case (h.kind)
      K_RST:   begin void'(q.pop_front()); q.push_back(f0_ent()); end
      K_F0:    begin void'(q.pop_front()); q.push_back(f1_ent()); end
      K_F1:    if (rdy) begin void'(q.pop_front()); push_instr(bus_if.in[15:0]); end
      K_EX:    if (!h.wait_rdy || rdy) void'(q.pop_front());
      default: ;
    endcase
    if (q.size() == 0) q.push_back(f0_ent());
  endtask

  task automatic model_check();
    ent_t h;
    out_t e;
    logic rdy, tk;
    h   = q[0];
    e   = h.exp;
    rdy = bus_if.mem_ready;
    if (h.kind == K_F1) e.reg_pc_inc = rdy;
    if (h.gate_rdy) begin
      e.reg_in_en = rdy;
      if (!rdy) e.reg_dst_sel = 3'd0;
    end
    if (h.jmp) begin
      tk = (h.mask == 4'h0) || ((bus_if.flags & h.mask) != 4'h0);
      e.reg_in_en = tk;
      if (!tk) e.reg_dst_sel = 3'd0;
    end
    chk("cycle_model", 64'(dut_outs()), 64'(e));
  endtask

  // One cycle: commit previous inputs to the model, drive new inputs, compare
  task automatic cycle(input logic r, input logic [DW-1:0] i, input logic [3:0] f, input logic m);
    @(negedge clk);
    model_advance();
    rst              = r;
    bus_if.in        = i;
    bus_if.flags     = f;
    bus_if.mem_ready = m;
    #1;
    model_check();
  endtask

  initial begin
    int halt_cnt;
    bus_if.in        = '0;
    bus_if.flags     = 4'h0;
    bus_if.mem_ready = 1'b1;
    q.push_back(new_ent(K_RST, 3'd0));

    // Reset
    cycle(1, 0, 0, 1);
    chk("rst_step", bus_if.step, 0);
    chk("rst_all_zero", 64'(dut_outs()), 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("f0_step", bus_if.step, 1);
    chk("f0_strobes", {bus_if.reg_out_en, bus_if.mem_addr_en, bus_if.reg_src_sel}, {2'b11, 3'd7});

    // Fetch stall, then LDI
    for (int k = 0; k < 3; k++) begin
      cycle(0, 20'h04A15, 0, 0);
      chk("stall_step", bus_if.step, 2);
      chk("stall_pc_inc", bus_if.reg_pc_inc, 0);
    end
    cycle(0, 20'h54A15, 0, 1);
    chk("fetch_pc_inc", bus_if.reg_pc_inc, 1);
    cycle(0, 0, 0, 1);
    chk("ldi_step", bus_if.step, 3);
    chk("ldi_pc_inc_off", bus_if.reg_pc_inc, 0);
    chk("ldi_strobes", {bus_if.ctl_out_en, bus_if.reg_dst_sel, bus_if.reg_in_en}, {1'b1, 3'd5, 1'b1});
    chk("ldi_out", bus_if.out, 20'h00015);
    cycle(0, 0, 0, 1);
    chk("ldi_back_f0", bus_if.step, 1);

    // ALU
    cycle(0, 20'h08280, 0, 1);
    cycle(0, 0, 0, 1);
    chk("alu_e1", {bus_if.reg_src_sel, bus_if.alu_ar_flag}, {3'd1, 1'b1});
    cycle(0, 0, 0, 1);
    chk("alu_e2", {bus_if.reg_src_sel, bus_if.alu_opcode}, {3'd2, 4'd8});
    cycle(0, 0, 0, 1);
    chk("alu_e3", {bus_if.alu_out_en, bus_if.reg_dst_sel, bus_if.reg_in_en}, {1'b1, 3'd1, 1'b1});
    cycle(0, 0, 0, 1);
    chk("alu_back_f0", bus_if.step, 1);

    // JMP taken / not taken
    cycle(0, 20'h050C1, 0, 1);
    cycle(0, 0, 4'b0001, 1);
    chk("jmp_taken", {bus_if.reg_src_sel, bus_if.reg_dst_sel, bus_if.reg_in_en}, {3'd3, 3'd7, 1'b1});
    cycle(0, 0, 0, 1);
    cycle(0, 20'h050C1, 0, 1);
    cycle(0, 0, 4'b0000, 1);
    chk("jmp_not_taken", bus_if.reg_in_en, 0);

    // HLT
    cycle(0, 0, 0, 1);
    cycle(0, 20'h07000, 0, 1);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 1);
      chk("halt_state", {bus_if.step, bus_if.halted}, {3'd7, 1'b1});
    end
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("halt_rst_step", bus_if.step, 0);

    // LD stalled in E2, then reset
    cycle(0, 0, 0, 1);
    cycle(0, 20'h02A40, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("ld_e2_stall", {bus_if.step, bus_if.mem_out_en, bus_if.reg_in_en}, {3'd4, 1'b1, 1'b0});
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("ld_rst_all_zero", 64'(dut_outs()), 0);

    // Random instruction stream
    halt_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      logic r;
      halt_cnt = (q[0].kind == K_HALT) ? halt_cnt + 1 : 0;
      r = ($urandom_range(0, 99) == 0) || (halt_cnt > 6);
      cycle(r, DW'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
